semaforo_ctrl: RTL and testbench
================================

SEMAFORO_CTRL -- requirements
Module: semaforo_ctrl

Interface
REQ-001 The block SHALL have parameter T_VERDE, default 5, seconds of green per direction (1..15).
REQ-002 The block SHALL have parameter T_AMARILLO, default 2, seconds of yellow per direction (1..15).
REQ-003 The block SHALL have parameter T_TODO_ROJO, default 1, seconds of all-red between directions (1..15).
REQ-004 The block SHALL have parameter T_PEATON, default 4, seconds of pedestrian walk phase (1..15).
REQ-005 The block SHALL have port clk, input, 1, system clock (50 MHz); the block runs on one clock, single domain.
REQ-006 The block SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-007 The block SHALL have port clk_n, input, 1, divided slow clock from the divider stage, sampled as data in the clk domain.
REQ-008 The block SHALL have port boton, input, 1, pedestrian request, level, already synchronous to clk.
REQ-009 The block SHALL have port luz_ns, output, 3, main road lights {rojo, amarillo, verde}, one-hot.
REQ-010 The block SHALL have port luz_eo, output, 3, side road lights {rojo, amarillo, verde}, one-hot.
REQ-011 The block SHALL have port peaton, output, 1, walk light.
REQ-012 The block SHALL have port seg_rest, output, 4, seconds remaining in current phase minus 1.
REQ-013 The block SHALL have port estado, output, 3, current state code (debug).

Function
REQ-014 The block SHALL generate an internal one-cycle tick when clk_n is 1 in the current cycle and was 0 in the previous cycle; this gives one tick per clk_n period.
REQ-015 The FSM states SHALL be NS_VERDE, NS_AMARILLO, ROJO_1, EO_VERDE, EO_AMARILLO, ROJO_2, PEATON.
REQ-016 The FSM SHALL advance NS_VERDE->NS_AMARILLO->ROJO_1->EO_VERDE->EO_AMARILLO->ROJO_2.
REQ-017 From ROJO_2 the FSM SHALL go to PEATON if a request is pending, else to NS_VERDE; PEATON SHALL go to NS_VERDE.
REQ-018 On entry to each state, seg_rest SHALL load (duration-1) for that state.
REQ-019 On each tick, seg_rest SHALL decrement when it is nonzero; when it is zero, the FSM SHALL take the transition instead.
REQ-020 The state change SHALL take effect the cycle after the tick, so each phase lasts exactly its duration in ticks.
REQ-021 luz_ns SHALL be verde in NS_VERDE, amarillo in NS_AMARILLO, and rojo in all other states; luz_eo SHALL follow the same pattern for the EO states.
REQ-022 peaton SHALL be 1 only in PEATON, and both roads SHALL be rojo in PEATON.
REQ-023 All outputs SHALL be registered, with no combinational path from inputs to outputs.
REQ-024 A boton=1 sample in any state except PEATON SHALL set the pending flag; the flag SHALL be cleared on entry to PEATON.
REQ-025 A press in the same cycle as the ROJO_2->PEATON transition SHALL be absorbed, with no second PEATON phase.
REQ-026 A press during PEATON SHALL be ignored.
REQ-027 Between ticks, all state SHALL hold; if clk_n is stuck, the FSM SHALL remain frozen indefinitely.

Reset
REQ-028 When rst=1, at the next clk edge: state NS_VERDE, seg_rest=T_VERDE-1, pending flag 0, luz_ns=verde, luz_eo=rojo, peaton=0, estado=NS_VERDE code.
REQ-029 The clk_n history register SHALL reset to 1, so that no tick is generated by a clk_n already high at reset release.
REQ-030 rst SHALL take priority over a coincident tick or boton, including mid-phase.

Configuration
REQ-031 Macro SEMAFORO_PEATON_EN defined: pedestrian flag and PEATON state are present as specified.
REQ-032 Macro not defined: boton is ignored, peaton is tied to 0, PEATON is unreachable or absent, and ROJO_2 always goes to NS_VERDE.

Structure
REQ-033 Package semaforo_pkg SHALL hold the state encoding constants (NS_VERDE=0 .. PEATON=6) and the light codes ROJO=3'b100, AMARILLO=3'b010, VERDE=3'b001.
REQ-034 Sub-module detector_flanco SHALL implement the clk_n rising-edge tick (REQ-014, REQ-029).
REQ-035 The rest of the FSM and timer SHALL be in semaforo_ctrl.

Verification
The following scenarios use T_VERDE=3, T_AMARILLO=2, T_TODO_ROJO=1, T_PEATON=4, and clk_n toggling every 5 clk cycles.
REQ-036 Reset release with clk_n=1 -> no tick; luz_ns=001, luz_eo=100, seg_rest=2.
REQ-037 Free run, boton=0 -> per-state tick counts 3,2,1,3,2,1 and a return to NS_VERDE after 12 ticks; peaton is never 1.
REQ-038 boton pulsed for 1 cycle during EO_VERDE -> PEATON entered after ROJO_2 for 4 ticks with peaton=1 and both roads 100; then NS_VERDE.
REQ-039 boton held high through PEATON -> exactly one PEATON phase, then a new request latches in NS_VERDE and is served on the next cycle.
REQ-040 rst asserted mid EO_AMARILLO, coincident with a tick -> next cycle shows NS_VERDE, seg_rest=2, pending=0.
REQ-041 Build without SEMAFORO_PEATON_EN with boton=1 constant -> same sequence as REQ-037.

Source files
------------

// File: rtl/semaforo_pkg.sv
// Shared types for the traffic-light controller: state codes, light codes, light payload.
package semaforo_pkg;

    localparam int unsigned LUZ_W = 3;
    localparam int unsigned SEG_W = 4;
    localparam int unsigned EST_W = 3;

    typedef enum logic [EST_W-1:0] {
        NS_VERDE    = 3'd0,
        NS_AMARILLO = 3'd1,
        ROJO_1      = 3'd2,
        EO_VERDE    = 3'd3,
        EO_AMARILLO = 3'd4,
        ROJO_2      = 3'd5,
        PEATON      = 3'd6
    } estado_t;

    // Light codes are {rojo, amarillo, verde}
    localparam logic [LUZ_W-1:0] ROJO     = 3'b100;
    localparam logic [LUZ_W-1:0] AMARILLO = 3'b010;
    localparam logic [LUZ_W-1:0] VERDE    = 3'b001;

    typedef struct packed {
        logic [LUZ_W-1:0] ns;
        logic [LUZ_W-1:0] eo;
    } luces_t;

    // Road lights shown in a given state; everything not green/yellow is red
    function automatic luces_t luces_de(estado_t s);
        luces_t l;
        l.ns = ROJO;
        l.eo = ROJO;
        case (s)
            NS_VERDE:    l.ns = VERDE;
            NS_AMARILLO: l.ns = AMARILLO;
            EO_VERDE:    l.eo = VERDE;
            EO_AMARILLO: l.eo = AMARILLO;
            default:     ;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/detector_flanco.sv
// Rising-edge detector for the slow clk_n, sampled as data in the clk domain.
// History resets high so a clk_n already high at reset release does not tick.
module detector_flanco (
    input  logic clk,
    input  logic rst,
    input  logic clk_n,
    output logic tick_c
);

    logic prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            prev <= 1'b1;
        end else begin
            prev <= clk_n;
        end
    end

    assign tick_c = clk_n & ~prev;

endmodule

// File: rtl/semaforo_ctrl.sv
// Two-road traffic-light controller with optional pedestrian phase.
// Pedestrian request/phase enabled by defining SEMAFORO_PEATON_EN.
module semaforo_ctrl
    import semaforo_pkg::*;
#(
    parameter int unsigned T_VERDE     = 5,
    parameter int unsigned T_AMARILLO  = 2,
    parameter int unsigned T_TODO_ROJO = 1,
    parameter int unsigned T_PEATON    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_n,
    input  logic             boton,
    output logic [LUZ_W-1:0] luz_ns,
    output logic [LUZ_W-1:0] luz_eo,
    output logic             peaton,
    output logic [SEG_W-1:0] seg_rest,
    output logic [EST_W-1:0] estado
);

    estado_t state;
    estado_t next_state;
    logic    tick;
    logic    fin_fase_c;
    luces_t  luces_nxt_c;
    logic    pend;

    detector_flanco u_detector (
        .clk    (clk),
        .rst    (rst),
        .clk_n  (clk_n),
        .tick_c (tick)
    );

    // Value seg_rest takes on entry to a state (duration minus one)
    function automatic logic [SEG_W-1:0] carga(estado_t s);
        logic [SEG_W-1:0] v;
        case (s)
            NS_VERDE, EO_VERDE:       v = SEG_W'(T_VERDE - 1);
            NS_AMARILLO, EO_AMARILLO: v = SEG_W'(T_AMARILLO - 1);
            ROJO_1, ROJO_2:           v = SEG_W'(T_TODO_ROJO - 1);
            PEATON:                   v = SEG_W'(T_PEATON - 1);
            default:                  v = SEG_W'(T_VERDE - 1);
        endcase
        return v;
    endfunction

    assign fin_fase_c = tick && (seg_rest == '0);

`ifdef SEMAFORO_PEATON_EN
    // Request latch: any sample outside PEATON sets it, entering PEATON clears it
    always_ff @(posedge clk) begin
        if (rst) begin
            pend <= 1'b0;
        end else if (next_state == PEATON && state != PEATON) begin
            pend <= 1'b0;
        end else if (boton && state != PEATON) begin
            pend <= 1'b1;
        end
    end
`else
    logic unused_boton;
    assign unused_boton = boton;
    assign pend         = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= NS_VERDE;
        end else begin
            state <= next_state;
        end
    end

    // Next state: move only on the tick that finds the phase counter at zero
    always_comb begin
        next_state = state;
        if (fin_fase_c) begin
            case (state)
                NS_VERDE:    next_state = NS_AMARILLO;
                NS_AMARILLO: next_state = ROJO_1;
                ROJO_1:      next_state = EO_VERDE;
                EO_VERDE:    next_state = EO_AMARILLO;
                EO_AMARILLO: next_state = ROJO_2;
                ROJO_2:      next_state = pend ? PEATON : NS_VERDE;
                PEATON:      next_state = NS_VERDE;
                default:     next_state = NS_VERDE;
            endcase
        end
    end

    // Phase timer
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_rest <= SEG_W'(T_VERDE - 1);
        end else if (tick) begin
            if (seg_rest != '0) begin
                seg_rest <= seg_rest - SEG_W'(1);
            end else begin
                seg_rest <= carga(next_state);
            end
        end
    end

    assign luces_nxt_c = luces_de(next_state);

    // Lights are registered from the next state so they change with the state
    always_ff @(posedge clk) begin
        if (rst) begin
            luz_ns <= VERDE;
            luz_eo <= ROJO;
        end else begin
            luz_ns <= luces_nxt_c.ns;
            luz_eo <= luces_nxt_c.eo;
        end
    end

`ifdef SEMAFORO_PEATON_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            peaton <= 1'b0;
        end else begin
            peaton <= (next_state == PEATON);
        end
    end
`else
    assign peaton = 1'b0;
`endif

    assign estado = state;

endmodule

// File: tb/tb_semaforo_ctrl.sv
// Self-checking bench for semaforo_ctrl against a phase/elapsed-tick reference model.
module tb_semaforo_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clk_n = 1'b1;
    logic       boton = 1'b0;
    logic [2:0] luz_ns;
    logic [2:0] luz_eo;
    logic       peaton;
    logic [3:0] seg_rest;
    logic [2:0] estado;

    semaforo_ctrl #(
        .T_VERDE     (3),
        .T_AMARILLO  (2),
        .T_TODO_ROJO (1),
        .T_PEATON    (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .clk_n    (clk_n),
        .boton    (boton),
        .luz_ns   (luz_ns),
        .luz_eo   (luz_eo),
        .peaton   (peaton),
        .seg_rest (seg_rest),
        .estado   (estado)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit ped_en;

    // Reference model: phase index (0..6 in spec order) and ticks elapsed in it
    int dur [7] = '{3, 2, 1, 3, 2, 1, 4};
    int m_ph = 0;
    int m_el = 0;
    bit m_pend = 0;
    bit m_prev = 1;
    bit m_tick = 0;
    int div_cnt = 0;
    bit cn_run = 0;

    wire [13:0] dut_vec = {luz_ns, luz_eo, peaton, seg_rest, estado};

    function automatic logic [13:0] exp_vec();
        logic [2:0] ns;
        logic [2:0] eo;
        logic       p;
        ns = (m_ph == 0) ? 3'b001 : (m_ph == 1) ? 3'b010 : 3'b100;
        eo = (m_ph == 3) ? 3'b001 : (m_ph == 4) ? 3'b010 : 3'b100;
        p  = (m_ph == 6);
        return {ns, eo, p, 4'(dur[m_ph] - 1 - m_el), 3'(m_ph)};
    endfunction

    task automatic model_edge();
        int old_ph;
        int nxt;
        bit enter_ped;
        m_tick = 1'b0;
        if (rst) begin
            m_ph = 0; m_el = 0; m_pend = 1'b0; m_prev = 1'b1;
            return;
        end
        m_tick = clk_n && !m_prev;
        m_prev = clk_n;
        old_ph = m_ph;
        enter_ped = 1'b0;
        if (m_tick) begin
            if (m_el == dur[m_ph] - 1) begin
                if (m_ph == 5)      nxt = (ped_en && m_pend) ? 6 : 0;
                else if (m_ph == 6) nxt = 0;
                else                nxt = m_ph + 1;
                enter_ped = (nxt == 6);
                m_ph = nxt;
                m_el = 0;
            end else begin
                m_el = m_el + 1;
            end
        end
        if (ped_en) begin
            if (enter_ped) m_pend = 1'b0;
            else if (boton && old_ph != 6) m_pend = 1'b1;
        end
    endtask

    // One clk cycle: model follows the edge, outputs are sampled 1 ns later
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        if (cn_run) begin
            div_cnt++;
            if (div_cnt == 5) begin
                div_cnt = 0;
                clk_n = ~clk_n;
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; clk_n = 1'b1; div_cnt = 0; boton = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        cn_run = 1'b0;
        rst = 1'b1; clk_n = 1'b1; boton = 1'b1;
        repeat (2) begin
            step();
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL reset_hold got %b want %b", dut_vec, exp_vec());
            end
        end
        rst = 1'b0; boton = 1'b0;
        repeat (20) begin
            step();
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL reset_release got %b want %b", dut_vec, exp_vec());
            end
        end
        checks++;
        if ({luz_ns, luz_eo, peaton, seg_rest, estado} !== {3'b001, 3'b100, 1'b0, 4'd2, 3'd0}) begin
            errors++;
            $display("FAIL reset_no_tick got %b want %b", dut_vec, {3'b001, 3'b100, 1'b0, 4'd2, 3'd0});
        end
    endtask

    task automatic test_free_run(input bit b);
        int cnt [8];
        int ticks;
        int budget;
        bit p_seen;
        logic [2:0] pre;
        foreach (cnt[i]) cnt[i] = 0;
        do_reset();
        boton = b; cn_run = 1'b1;
        ticks = 0; budget = 0; p_seen = 1'b0;
        while (ticks < 12 && budget < 400) begin
            pre = estado;
            step();
            budget++;
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL free_run got %b want %b", dut_vec, exp_vec());
            end
            if (m_tick) begin
                cnt[pre]++;
                ticks++;
            end
            if (peaton) p_seen = 1'b1;
        end
        checks++;
        if (ticks != 12) begin
            errors++;
            $display("FAIL free_run_timeout got %0d ticks want 12", ticks);
        end
        checks++;
        if ({cnt[0], cnt[1], cnt[2], cnt[3], cnt[4], cnt[5]} !== {32'd3, 32'd2, 32'd1, 32'd3, 32'd2, 32'd1}) begin
            errors++;
            $display("FAIL free_run_counts got %0d %0d %0d %0d %0d %0d want 3 2 1 3 2 1",
                     cnt[0], cnt[1], cnt[2], cnt[3], cnt[4], cnt[5]);
        end
        checks++;
        if (estado !== 3'd0 || p_seen) begin
            errors++;
            $display("FAIL free_run_wrap got estado %0d peaton_seen %0d want 0 0", estado, p_seen);
        end
        boton = 1'b0;
    endtask

    task automatic test_ped_pulse();
        int budget;
        int pt;
        bit seen5;
        bit pre_p;
        do_reset();
        cn_run = 1'b1;
        budget = 0;
        while (!(m_ph == 3 && m_el == 1) && budget < 300) begin
            step(); budget++;
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL ped_pulse_pre got %b want %b", dut_vec, exp_vec());
            end
        end
        boton = 1'b1;
        step();
        boton = 1'b0;
        seen5 = 1'b0; pt = 0; budget = 0;
        while (!(seen5 && m_ph == 0) && budget < 300) begin
            pre_p = peaton;
            step(); budget++;
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL ped_pulse got %b want %b", dut_vec, exp_vec());
            end
            if (m_ph == 5) seen5 = 1'b1;
            if (pre_p && m_tick) pt++;
            if (peaton) begin
                checks++;
                if ({luz_ns, luz_eo} !== 6'b100100) begin
                    errors++;
                    $display("FAIL ped_all_red got %b want 100100", {luz_ns, luz_eo});
                end
            end
        end
        checks++;
        if (pt != (ped_en ? 4 : 0) || estado !== 3'd0) begin
            errors++;
            $display("FAIL ped_pulse_len got %0d ticks estado %0d want %0d ticks estado 0",
                     pt, estado, ped_en ? 4 : 0);
        end
    endtask

    task automatic test_ped_held();
        int budget;
        int entries;
        int exits5;
        bit pre_p;
        bit pre5;
        do_reset();
        cn_run = 1'b1;
        budget = 0; entries = 0; exits5 = 0;
        while (exits5 < 2 && budget < 600) begin
            if (m_ph == 5 && exits5 == 0) boton = 1'b1;
            if (m_ph == 0 && exits5 == 1 && m_el >= 1) boton = 1'b0;
            pre_p = peaton;
            pre5 = (estado == 3'd5);
            step(); budget++;
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL ped_held got %b want %b", dut_vec, exp_vec());
            end
            if (!pre_p && peaton) entries++;
            if (pre5 && estado != 3'd5) exits5++;
        end
        boton = 1'b0;
        checks++;
        if (entries != (ped_en ? 2 : 0) || estado !== (ped_en ? 3'd6 : 3'd0)) begin
            errors++;
            $display("FAIL ped_held_count got %0d phases estado %0d want %0d phases",
                     entries, estado, ped_en ? 2 : 0);
        end
    endtask

    task automatic test_reset_mid();
        int budget;
        bit p_seen;
        bit pre5;
        int exits5;
        do_reset();
        cn_run = 1'b1;
        boton = 1'b1;
        step();
        boton = 1'b0;
        budget = 0;
        while (!(m_ph == 4 && clk_n && !m_prev) && budget < 300) begin
            step(); budget++;
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if ({luz_ns, luz_eo, peaton, seg_rest, estado} !== {3'b001, 3'b100, 1'b0, 4'd2, 3'd0}) begin
            errors++;
            $display("FAIL reset_mid got %b want %b", dut_vec, {3'b001, 3'b100, 1'b0, 4'd2, 3'd0});
        end
        p_seen = 1'b0; exits5 = 0; budget = 0;
        while (exits5 < 1 && budget < 300) begin
            pre5 = (estado == 3'd5);
            step(); budget++;
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL reset_mid_run got %b want %b", dut_vec, exp_vec());
            end
            if (peaton) p_seen = 1'b1;
            if (pre5 && estado != 3'd5) exits5++;
        end
        checks++;
        if (p_seen || exits5 != 1) begin
            errors++;
            $display("FAIL reset_mid_pending got peaton_seen %0d exits %0d want 0 1", p_seen, exits5);
        end
    endtask

    task automatic test_random();
        do_reset();
        cn_run = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            boton = ($urandom_range(0, 19) == 0);
            rst   = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 299) == 0) cn_run = ~cn_run;
            step();
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL random cycle %0d got %b want %b", i, dut_vec, exp_vec());
            end
        end
        rst = 1'b0; boton = 1'b0; cn_run = 1'b1;
    endtask

    initial begin
`ifdef SEMAFORO_PEATON_EN
        ped_en = 1'b1;
`else
        ped_en = 1'b0;
`endif
        test_reset();
        test_free_run(1'b0);
        if (!ped_en) test_free_run(1'b1);
        test_ped_pulse();
        test_ped_held();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
